// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    // Width of a counter that must hold the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sub_borrow.sv
// W-bit subtractor a - b with a borrow-out; the subtract dual of the n-bit adder.
module sub_borrow #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] wide;

    assign wide   = {1'b0, a} - {1'b0, b};
    assign diff   = wide[W-1:0];
    assign borrow = wide[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_w(N);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
    div_state_t    state, state_next;
    logic [N:0]    rem;
    logic [N-1:0]  q;
    logic [N-1:0]  dvsr;
    logic [CW-1:0] count;

    logic          accept;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          borrow;
    logic [N:0]    rem_next;
    logic [N-1:0]  q_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // rem[N] is always 0 between steps, so the left shift drops nothing.
    assign shifted = (rem << 1) | {{N{1'b0}}, q[N-1]};

    sub_borrow #(.W(N + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvsr}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_next = borrow ? shifted : trial;
    assign q_next   = {q[N-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            q           <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvsr <= divisor;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                rem   <= '0;
                q     <= dividend;
                count <= CW'(N);
            end
        end else if (state == CALC) begin
            rem   <= rem_next;
            q     <= q_next;
            count <= count - CW'(1);
            // Last step: publish the result straight from the final shift.
            if (count == CW'(1)) begin
                quotient    <= q_next;
                remainder   <= rem_next[N-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed corner cases plus random operands.
module tb_seq_restoring_divider;

    localparam int N  = 16;
    localparam int RW = 2 * N + 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int failures;
    int cyc;
    int rdy_mode;
    logic prev_valid;

    logic [RW-1:0] exp_q[$];
    int            acc_q[$];
    int            exp_lat_q[$];

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock, edge counter and consumer-side ready generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: compares the presented result against the head of the expected queue
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid q=%0h r=%0h dbz=%0b", quotient, remainder, div_by_zero);
                end else begin
                    checks++;
                    if ({div_by_zero, quotient, remainder} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL result got q=%0h r=%0h dbz=%0b exp q=%0h r=%0h dbz=%0b",
                                 quotient, remainder, div_by_zero,
                                 exp_q[0][2*N-1:N], exp_q[0][N-1:0], exp_q[0][2*N]);
                    end
                    if (!prev_valid && acc_q.size() > 0 && exp_lat_q.size() > 0) begin
                        chk("latency", 64'(cyc - acc_q.pop_front() + 1), 64'(exp_lat_q.pop_front()));
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    // Driver: called at posedge+1; waits for in_ready, presents operands for one edge
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%0b exp=1", in_ready);
            return;
        end
        exp_q.push_back({edbz, eq, er});
        exp_lat_q.push_back((b == '0) ? 1 : N + 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    task automatic send_rand(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == '0) send(a, b, '1, a, 1'b1);
        else         send(a, b, a / b, a % b, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
            exp_lat_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_quotient"}, 64'(quotient), 64'd0);
        chk({tag, "_remainder"}, 64'(remainder), 64'd0);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        #1_500_000;
        failures++;
        $display("FAIL watchdog cycles=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rdy_mode  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic division, max dividend, dividend below divisor
        send(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0);
        send(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        drain();

        // Divide by zero, then a normal result clears the flag
        send(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        send(16'd6, 16'd3, 16'd2, 16'd0, 1'b0);
        send(16'd1234, 16'd1234, 16'd1, 16'd0, 1'b0);
        send(16'd0, 16'd9, 16'd0, 16'd0, 1'b0);
        drain();

        // Backpressure with ignored operand pulses during CALC and DONE
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0);
        for (int i = 0; i < 40 && !out_valid; i++) begin
            in_valid = 1'b1;
            dividend = 16'd77;
            divisor  = 16'd5;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 16'd200;
            divisor  = 16'd0;
            chk("busy_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("held_valid", 64'(out_valid), 64'd1);
        rdy_mode = 0;
        drain();

        // Reset during CALC discards the in-flight result
        send(16'd50000, 16'd7, 16'd7142, 16'd6, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        exp_lat_q.delete();
        #1;
        check_reset_outputs("midcalc");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(16'd9, 16'd4, 16'd2, 16'd1, 1'b0);
        drain();

        // Random operands with random consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < 2500; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            int gap;
            int sel;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            a   = N'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                2:       b = a;
                3:       b = a + N'(1);
                4:       b = N'(1);
                default: b = N'($urandom);
            endcase
            send_rand(a, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
